// File: rtl/rosco_pkg.sv
// Shared definitions for the bus arbitration glue: FSM state type and
// default timing constants.
package rosco_pkg;

  typedef enum logic [2:0] {
    ARB_IDLE     = 3'd0,
    ARB_REQ      = 3'd1,
    ARB_WAIT_BUS = 3'd2,
    ARB_GRANT    = 3'd3,
    ARB_RELEASE  = 3'd4,
    ARB_HOLDOFF  = 3'd5
  } arb_state_t;

  // Cycles of bus ownership before the winner is told to get off the bus.
  localparam int ARB_MAX_TENURE = 64;

  // Idle cycles guaranteed to the CPU after every DMA tenure.
  localparam int ARB_CPU_SLOTS  = 4;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin select: first requesting index after last_winner,
// scanning circularly.
module rr_picker #(
  parameter int NREQ = 2,
  parameter int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDXW-1:0] last_winner,
  output logic [IDXW-1:0] winner,
  output logic            valid
);

  logic [IDXW-1:0] idx;

  // Scan from last_winner+1 around the ring; lowest circular distance wins.
  always_comb begin
    // NOTE: every output gets a default before the loop so no latch is inferred.
    winner = '0;
    valid  = 1'b0;
    idx    = '0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = IDXW'((int'(last_winner) + i) % NREQ);
      if (!valid && req[idx]) begin
        valid  = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous single-bit inputs.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Shift the asynchronous input through two flops to resolve metastability.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep both flops sampling the pre-edge values.
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// 68000 bus arbiter: runs BR/BG/BGACK on behalf of NREQ DMA masters,
// round-robin winner selection, advisory preemption after MAX_TENURE cycles.
module bus_arbiter
  import rosco_pkg::*;
#(
  parameter int NREQ       = 2,
  parameter int MAX_TENURE = ARB_MAX_TENURE,
  parameter int CPU_SLOTS  = ARB_CPU_SLOTS
) (
  input  logic            i_CLK,
  input  logic            i_RST,
  input  logic [NREQ-1:0] i_REQ,
  input  logic            i_BG_n,
  input  logic            i_AS_n,
  input  logic            i_BGACK_n,
  output logic            o_BR_n,
  output logic            o_BGACK_n,
  output logic [NREQ-1:0] o_GNT,
  output logic            o_PREEMPT
);

  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TW   = (MAX_TENURE > 0) ? $clog2(MAX_TENURE + 1) : 1;
  localparam int CW   = (CPU_SLOTS > 0) ? $clog2(CPU_SLOTS + 1) : 1;

  arb_state_t      state;
  logic [IDXW-1:0] winner;
  logic [IDXW-1:0] last_winner;
  logic [TW-1:0]   tenure;
  logic [TW-1:0]   tenure_inc;
  logic [CW-1:0]   slot_cnt;
  logic [IDXW-1:0] pick_idx;
  logic            pick_valid;
  logic [NREQ-1:0] win_onehot;
  logic            bg_s;
  logic            as_s;
  logic            bgack_s;

  // The CPU-side handshake lines are asynchronous to i_CLK; every decision
  // below looks only at the synchronised copies.
  sync_2ff #(.RST_VAL(1'b1)) u_sync_bg (
    .clk (i_CLK), .rst (i_RST), .d (i_BG_n),    .q (bg_s)
  );
  sync_2ff #(.RST_VAL(1'b1)) u_sync_as (
    .clk (i_CLK), .rst (i_RST), .d (i_AS_n),    .q (as_s)
  );
  sync_2ff #(.RST_VAL(1'b1)) u_sync_bgack (
    .clk (i_CLK), .rst (i_RST), .d (i_BGACK_n), .q (bgack_s)
  );

  rr_picker #(.NREQ(NREQ), .IDXW(IDXW)) u_picker (
    .req         (i_REQ),
    .last_winner (last_winner),
    .winner      (pick_idx),
    .valid       (pick_valid)
  );

  assign win_onehot = NREQ'(1) << winner;

  // Tenure counter saturates so preemption stays asserted once reached.
  always_comb begin
    tenure_inc = tenure;
    if (tenure != TW'(MAX_TENURE)) tenure_inc = tenure + 1'b1;
  end

  // Arbitration FSM; all outputs are registered and change only with state.
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state       <= ARB_IDLE;
      winner      <= '0;
      last_winner <= IDXW'(NREQ - 1);
      tenure      <= '0;
      slot_cnt    <= '0;
      o_BR_n      <= 1'b1;
      o_BGACK_n   <= 1'b1;
      o_GNT       <= '0;
      o_PREEMPT   <= 1'b0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (pick_valid) begin
            winner <= pick_idx;
            o_BR_n <= 1'b0;
            state  <= ARB_REQ;
          end
        end

        ARB_REQ: begin
          // A winner that gives up before BG arrives abandons the request.
          if (!i_REQ[winner]) begin
            o_BR_n <= 1'b1;
            state  <= ARB_IDLE;
          end else if (!bg_s) begin
            state <= ARB_WAIT_BUS;
          end
        end

        ARB_WAIT_BUS: begin
          // Take the bus only once the CPU's last cycle and any other master
          // have finished; BR negates on the same edge BGACK asserts.
          if (as_s && bgack_s) begin
            o_BGACK_n   <= 1'b0;
            o_GNT       <= win_onehot;
            o_BR_n      <= 1'b1;
            tenure      <= '0;
            last_winner <= winner;
            state       <= ARB_GRANT;
          end
        end

        ARB_GRANT: begin
          if (!i_REQ[winner] && as_s) begin
            o_GNT     <= '0;
            o_BGACK_n <= 1'b1;
            o_PREEMPT <= 1'b0;
            state     <= ARB_RELEASE;
          end else begin
            tenure <= tenure_inc;
            if (tenure_inc == TW'(MAX_TENURE)) o_PREEMPT <= 1'b1;
          end
        end

        ARB_RELEASE: begin
          if (CPU_SLOTS == 0) begin
            state <= ARB_IDLE;
          end else begin
            slot_cnt <= CW'(CPU_SLOTS);
            state    <= ARB_HOLDOFF;
          end
        end

        ARB_HOLDOFF: begin
          if (slot_cnt <= CW'(1)) begin
            slot_cnt <= '0;
            state    <= ARB_IDLE;
          end else begin
            slot_cnt <= slot_cnt - 1'b1;
          end
        end

        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: the bench plays the 68000 (BG/AS)
// and the DMA masters, and predicts grants from the round-robin rule.
module tb_bus_arbiter;

  localparam int NREQ    = 2;
  localparam int MAX_TEN = 8;
  localparam int SLOTS   = 4;

  logic            i_CLK     = 1'b0;
  logic            i_RST     = 1'b1;
  logic [NREQ-1:0] i_REQ     = '0;
  logic            i_BG_n    = 1'b1;
  logic            i_AS_n    = 1'b1;
  logic            i_BGACK_n = 1'b1;
  logic            o_BR_n;
  logic            o_BGACK_n;
  logic [NREQ-1:0] o_GNT;
  logic            o_PREEMPT;

  int tests    = 0;
  int fails    = 0;
  int last_win = NREQ - 1;
  int cur_win  = 0;

  bus_arbiter #(.NREQ(NREQ), .MAX_TENURE(MAX_TEN), .CPU_SLOTS(SLOTS)) dut (
    .i_CLK     (i_CLK),
    .i_RST     (i_RST),
    .i_REQ     (i_REQ),
    .i_BG_n    (i_BG_n),
    .i_AS_n    (i_AS_n),
    .i_BGACK_n (i_BGACK_n),
    .o_BR_n    (o_BR_n),
    .o_BGACK_n (o_BGACK_n),
    .o_GNT     (o_GNT),
    .o_PREEMPT (o_PREEMPT)
  );

  always #5 i_CLK = ~i_CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock, sample 1 ns after the edge and check bus invariants.
  task automatic tick();
    @(posedge i_CLK);
    #1;
    check("gnt_onehot0", 32'($onehot0(o_GNT)), 1);
    check("gnt_iff_bgack", 32'(o_GNT != '0), 32'(o_BGACK_n == 1'b0));
    check("br_bgack_excl", 32'(!(o_BR_n == 1'b0 && o_BGACK_n == 1'b0)), 1);
  endtask

  // Reference rule: first requester after the previous winner, circularly.
  function automatic int rr_next(input logic [NREQ-1:0] req, input int last);
    for (int k = 1; k <= NREQ; k++)
      if (req[(last + k) % NREQ]) return (last + k) % NREQ;
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] onehot(input int idx);
    logic [NREQ-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Wait for BR, drop BG after bg_lat cycles with AS held low for as_hold
  // cycles after that, and check the grant lands exactly when predicted.
  task automatic acquire(input int bg_lat, input int as_hold);
    int n;
    int exp_w;
    int t;
    exp_w = rr_next(i_REQ, last_win);
    n = 0;
    while (o_BR_n !== 1'b0 && n < 40) begin
      tick();
      n++;
    end
    check("br_asserted", 32'(o_BR_n), 0);
    check("no_gnt_before_bg", 32'(o_GNT), 0);
    if (as_hold > 0) i_AS_n = 1'b0;
    for (int k = 0; k < bg_lat; k++) begin
      tick();
      check("br_held", 32'(o_BR_n), 0);
    end
    i_BG_n = 1'b0;
    // BG: 2 sync edges + REQ->WAIT_BUS + WAIT_BUS->GRANT; AS: 2 sync + 1.
    t = (as_hold + 3 > 4) ? as_hold + 3 : 4;
    for (int k = 1; k <= t; k++) begin
      tick();
      if (k == as_hold) i_AS_n = 1'b1;
      if (k < t) check("gnt_too_early", 32'(o_GNT), 0);
    end
    check("gnt_winner", 32'(o_GNT), 32'(onehot(exp_w)));
    check("bgack_on_gnt", 32'(o_BGACK_n), 0);
    check("br_off_on_gnt", 32'(o_BR_n), 1);
    check("preempt_at_gnt", 32'(o_PREEMPT), 0);
    i_BG_n   = 1'b1;
    last_win = exp_w;
    cur_win  = exp_w;
  endtask

  // Hold the bus for `hold` cycles, release, then check the CPU holdoff.
  task automatic hold_release(input int hold, input logic [NREQ-1:0] next_mask);
    for (int j = 1; j <= hold; j++) begin
      tick();
      check("gnt_held", 32'(o_GNT), 32'(onehot(cur_win)));
      check("preempt", 32'(o_PREEMPT), 32'(j >= MAX_TEN));
    end
    i_REQ[cur_win] = 1'b0;
    tick();
    check("rel_gnt", 32'(o_GNT), 0);
    check("rel_bgack", 32'(o_BGACK_n), 1);
    check("rel_preempt", 32'(o_PREEMPT), 0);
    i_REQ = next_mask;
    for (int j = 1; j <= SLOTS; j++) begin
      tick();
      check("holdoff_br", 32'(o_BR_n), 1);
    end
  endtask

  initial begin
    int n;

    // Reset values.
    repeat (3) @(posedge i_CLK);
    #1;
    check("rst_br", 32'(o_BR_n), 1);
    check("rst_bgack", 32'(o_BGACK_n), 1);
    check("rst_gnt", 32'(o_GNT), 0);
    check("rst_preempt", 32'(o_PREEMPT), 0);
    i_RST = 1'b0;

    // Single request, BG 3 cycles after BR.
    i_REQ = 2'b01;
    acquire(3, 0);
    hold_release(5, 2'b00);

    // Both requesting throughout; each tenure lasts 10 cycles.
    i_REQ = 2'b11;
    for (int r = 0; r < 4; r++) begin
      acquire(int'($urandom_range(1, 4)), 0);
      hold_release(10, (r == 3) ? 2'b00 : 2'b11);
    end

    // Abort: request withdrawn before BG.
    i_REQ = 2'b01;
    n = 0;
    while (o_BR_n !== 1'b0 && n < 40) begin
      tick();
      n++;
    end
    check("abort_br_low", 32'(o_BR_n), 0);
    i_REQ = 2'b00;
    tick();
    check("abort_br_high", 32'(o_BR_n), 1);
    for (int k = 0; k < 6; k++) begin
      tick();
      check("abort_no_gnt", 32'(o_GNT), 0);
      check("abort_br_idle", 32'(o_BR_n), 1);
    end
    // Back in IDLE: a fresh request raises BR on the very next edge.
    i_REQ = 2'b10;
    tick();
    check("idle_after_abort", 32'(o_BR_n), 0);

    // AS still low for 5 cycles after BG drops.
    acquire(2, 5);
    hold_release(3, 2'b00);

    // Long tenure: preemption from grant+MAX_TEN until release.
    i_REQ = 2'b01;
    acquire(3, 0);
    hold_release(20, 2'b00);

    // Randomised request masks, latencies and tenures.
    i_REQ = NREQ'($urandom_range(1, 3));
    for (int r = 0; r < 8; r++) begin
      acquire(int'($urandom_range(1, 5)), int'($urandom_range(0, 4)));
      hold_release(int'($urandom_range(1, 12)), NREQ'($urandom_range(1, 3)));
    end

    // Reset while requester 0 holds the bus and requester 1 is waiting.
    i_REQ = 2'b01;
    acquire(2, 0);
    i_REQ = 2'b11;
    repeat (3) tick();
    i_RST = 1'b1;
    tick();
    check("mid_rst_gnt", 32'(o_GNT), 0);
    check("mid_rst_bgack", 32'(o_BGACK_n), 1);
    check("mid_rst_br", 32'(o_BR_n), 1);
    check("mid_rst_preempt", 32'(o_PREEMPT), 0);
    i_RST    = 1'b0;
    last_win = NREQ - 1;
    acquire(2, 0);
    check("first_after_rst", 32'(cur_win), 0);
    hold_release(4, 2'b00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
